// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - playfield geometry shared by engine, renderer, player controller and enemy shots
package game_pkg;

  localparam int unsigned COORD_W  = 10;
  localparam int unsigned N_ENEMY  = 24;
  localparam int unsigned COLS     = 8;
  localparam int unsigned ENEMY_DX = 40;
  localparam int unsigned ENEMY_DY = 32;
  localparam int unsigned ENEMY_W  = 32;
  localparam int unsigned ENEMY_H  = 24;
  localparam int unsigned SHOT_DY  = 4;
  localparam int unsigned SHOT_W   = 2;
  localparam int unsigned SHOT_H   = 8;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned PLAYER_Y = 440;
  localparam int unsigned PLAYER_W = 32;
  localparam int unsigned PLAYER_H = 16;
  localparam int unsigned LIVES    = 3;

  localparam int unsigned ENEMY_IDX_W = $clog2(N_ENEMY);

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COORD_W:0]   coord_ext_t;

  // Muzzle point: horizontally centred under the enemy sprite, at its bottom edge.
  function automatic coord_t spawn_x(coord_t fx, logic [ENEMY_IDX_W-1:0] idx);
    int unsigned v;
    v = 32'(fx) + (32'(idx) % COLS) * ENEMY_DX + ENEMY_W / 2;
    return coord_t'(v);
  endfunction

  function automatic coord_t spawn_y(coord_t fy, logic [ENEMY_IDX_W-1:0] idx);
    int unsigned v;
    v = 32'(fy) + (32'(idx) / COLS) * ENEMY_DY + ENEMY_H;
    return coord_t'(v);
  endfunction

endpackage

// File: rtl/shot_slot.sv
// rtl/shot_slot.sv - one enemy projectile register with move, retire and player-overlap logic
module shot_slot
  import game_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   restart,
  input  logic   kill,
  input  logic   load,
  input  coord_t load_x,
  input  coord_t load_y,
  input  logic   tick,
  input  coord_t player_x,
  output logic   active,
  output coord_t x,
  output coord_t y,
  output logic   hit
);

  logic       active_q, active_d;
  coord_t     x_q, x_d, y_q, y_d;
  coord_ext_t y_mv, x_ext, px_ext;
  logic       retire, overlap;

  // Hit test runs on the post-move position, so both use y_mv.
  always_comb begin
    y_mv    = {1'b0, y_q} + coord_ext_t'(SHOT_DY);
    x_ext   = {1'b0, x_q};
    px_ext  = {1'b0, player_x};
    retire  = y_mv >= coord_ext_t'(SCREEN_H);
    overlap = (x_ext < px_ext + coord_ext_t'(PLAYER_W)) &&
              (x_ext + coord_ext_t'(SHOT_W) > px_ext) &&
              (y_mv + coord_ext_t'(SHOT_H) > coord_ext_t'(PLAYER_Y)) &&
              (y_mv < coord_ext_t'(PLAYER_Y + PLAYER_H));
    hit     = tick && active_q && !retire && overlap;
  end

  always_comb begin
    active_d = active_q;
    x_d      = x_q;
    y_d      = y_q;
    if (restart) begin
      active_d = 1'b0;
      x_d      = '0;
      y_d      = '0;
    end else if (kill) begin
      active_d = 1'b0;
    end else if (load) begin
      active_d = 1'b1;
      x_d      = load_x;
      y_d      = load_y;
    end else if (tick && active_q) begin
      y_d = y_mv[COORD_W-1:0];
      if (retire || overlap) active_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      active_q <= active_d;
      x_q      <= x_d;
      y_q      <= y_d;
    end
  end

  assign active = active_q;
  assign x      = x_q;
  assign y      = y_q;

endmodule

// File: rtl/enemy_shot_manager.sv
// rtl/enemy_shot_manager.sv - enemy projectile spawn/step/hit and player lives; ENEMY_SHOT_SHIELD_EN adds post-hit shield
module enemy_shot_manager
  import game_pkg::*;
#(
  parameter int unsigned N_SHOTS     = 4,
  parameter int unsigned STEP_CYCLES = 500000
`ifdef ENEMY_SHOT_SHIELD_EN
  , parameter int unsigned SHIELD_STEPS = 64
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       restart,
  input  logic [N_ENEMY-1:0]         ID_enemy_tiro,
  input  logic [COORD_W-1:0]         formation_x,
  input  logic [COORD_W-1:0]         formation_y,
  input  logic [COORD_W-1:0]         player_x,
  output logic [N_SHOTS-1:0]         shot_active,
  output logic [COORD_W*N_SHOTS-1:0] shot_x,
  output logic [COORD_W*N_SHOTS-1:0] shot_y,
  output logic                       player_hit,
  output logic [1:0]                 lives,
  output logic                       jogador_vivo,
  output logic                       shot_dropped
`ifdef ENEMY_SHOT_SHIELD_EN
  , output logic                     shield_on
`endif
);

  localparam int unsigned CNT_W      = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int unsigned SLOT_W     = (N_SHOTS > 1) ? $clog2(N_SHOTS) : 1;
  localparam logic [1:0]  LIVES_INIT = 2'(LIVES);

  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [1:0]             lives_q, lives_d;
  logic                   vivo_q, vivo_d, hit_q, hit_d, drop_q, drop_d;
  logic                   req_valid, free_found, spawn_go, tick, any_hit, count_hit, kill;
  logic [ENEMY_IDX_W-1:0] sel_idx;
  logic [SLOT_W-1:0]      free_idx;
  logic [N_SHOTS-1:0]     slot_active, slot_hit, slot_load;
  coord_t                 spawn_xv, spawn_yv;

  // Stepping freezes once the player is dead.
  assign tick = vivo_q && (cnt_q == CNT_W'(STEP_CYCLES - 1));

  always_comb begin
    req_valid = 1'b0;
    sel_idx   = '0;
    for (int i = N_ENEMY - 1; i >= 0; i--) begin
      if (ID_enemy_tiro[i]) begin
        req_valid = 1'b1;
        sel_idx   = ENEMY_IDX_W'(i);
      end
    end
    free_found = 1'b0;
    free_idx   = '0;
    for (int k = N_SHOTS - 1; k >= 0; k--) begin
      if (!slot_active[k]) begin
        free_found = 1'b1;
        free_idx   = SLOT_W'(k);
      end
    end
  end

  assign spawn_go = req_valid && vivo_q && free_found && !restart;
  assign spawn_xv = spawn_x(formation_x, sel_idx);
  assign spawn_yv = spawn_y(formation_y, sel_idx);
  assign any_hit  = |slot_hit;

`ifdef ENEMY_SHOT_SHIELD_EN
  localparam int unsigned SHIELD_W = $clog2(SHIELD_STEPS + 1);
  logic [SHIELD_W-1:0] shield_q, shield_d;

  assign count_hit = any_hit && (shield_q == '0);

  always_comb begin
    shield_d = shield_q;
    if (restart)                      shield_d = '0;
    else if (count_hit)               shield_d = SHIELD_W'(SHIELD_STEPS);
    else if (tick && shield_q != '0)  shield_d = shield_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) shield_q <= '0;
    else        shield_q <= shield_d;
  end

  assign shield_on = (shield_q != '0);
`else
  assign count_hit = any_hit;
`endif

  // Losing the last life clears every slot in the same cycle.
  assign kill = count_hit && (lives_q == 2'd1) && !restart;

  always_comb begin
    cnt_d   = cnt_q;
    lives_d = lives_q;
    hit_d   = 1'b0;
    drop_d  = 1'b0;
    if (restart) begin
      cnt_d   = '0;
      lives_d = LIVES_INIT;
    end else begin
      if (vivo_q) cnt_d = tick ? '0 : cnt_q + 1'b1;
      if (count_hit) begin
        hit_d = 1'b1;
        if (lives_q != 2'd0) lives_d = lives_q - 1'b1;
      end
      drop_d = req_valid && vivo_q && !free_found;
    end
    vivo_d = (lives_d != 2'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      lives_q <= LIVES_INIT;
      vivo_q  <= 1'b1;
      hit_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      lives_q <= lives_d;
      vivo_q  <= vivo_d;
      hit_q   <= hit_d;
      drop_q  <= drop_d;
    end
  end

  for (genvar k = 0; k < N_SHOTS; k++) begin : g_slot
    assign slot_load[k] = spawn_go && (free_idx == SLOT_W'(k));
    shot_slot u_slot (
      .clk      (clk),
      .rst_n    (reset),
      .restart  (restart),
      .kill     (kill),
      .load     (slot_load[k]),
      .load_x   (spawn_xv),
      .load_y   (spawn_yv),
      .tick     (tick),
      .player_x (player_x),
      .active   (slot_active[k]),
      .x        (shot_x[COORD_W*k +: COORD_W]),
      .y        (shot_y[COORD_W*k +: COORD_W]),
      .hit      (slot_hit[k])
    );
  end

  assign shot_active  = slot_active;
  assign player_hit   = hit_q;
  assign lives        = lives_q;
  assign jogador_vivo = vivo_q;
  assign shot_dropped = drop_q;

endmodule

// File: tb/tb_enemy_shot_manager.sv
// tb/tb_enemy_shot_manager.sv - directed self-checking bench for enemy_shot_manager (step = 4 cycles)
module tb_enemy_shot_manager;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        restart = 1'b0;
  logic [23:0] id_tiro = '0;
  logic [9:0]  formation_x = '0;
  logic [9:0]  formation_y = '0;
  logic [9:0]  player_x = '0;
  logic [3:0]  shot_active;
  logic [39:0] shot_x, shot_y;
  logic        player_hit, jogador_vivo, shot_dropped;
  logic [1:0]  lives;
`ifdef ENEMY_SHOT_SHIELD_EN
  logic        shield_on;
`endif

  int vectors = 0;
  int miscompares = 0;

  enemy_shot_manager #(.N_SHOTS(4), .STEP_CYCLES(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .restart       (restart),
    .ID_enemy_tiro (id_tiro),
    .formation_x   (formation_x),
    .formation_y   (formation_y),
    .player_x      (player_x),
    .shot_active   (shot_active),
    .shot_x        (shot_x),
    .shot_y        (shot_y),
    .player_hit    (player_hit),
    .lives         (lives),
    .jogador_vivo  (jogador_vivo),
    .shot_dropped  (shot_dropped)
`ifdef ENEMY_SHOT_SHIELD_EN
    , .shield_on   (shield_on)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    id_tiro = 24'hffffff;
    step();
    step();
    vectors++; if (shot_active !== 4'b0000) begin miscompares++; $display("FAIL reset_active got %b exp 0000", shot_active); end
    vectors++; if (lives !== 2'd3) begin miscompares++; $display("FAIL reset_lives got %0d exp 3", lives); end
    vectors++; if (jogador_vivo !== 1'b1) begin miscompares++; $display("FAIL reset_vivo got %b exp 1", jogador_vivo); end
    vectors++; if (shot_x !== 40'd0 || shot_y !== 40'd0) begin miscompares++; $display("FAIL reset_xy got %h/%h exp 0", shot_x, shot_y); end
    vectors++; if (player_hit !== 1'b0 || shot_dropped !== 1'b0) begin miscompares++; $display("FAIL reset_pulses got %b%b exp 00", player_hit, shot_dropped); end
    id_tiro = '0;
    reset   = 1'b1;
    step();
  endtask

  task automatic test_spawn();
    formation_x = 10'd100; formation_y = 10'd50; player_x = 10'd150;
    do_restart();
    id_tiro = (24'd1 << 9) | (24'd1 << 20);
    step();
    id_tiro = 24'd1 << 23;
    vectors++; if (shot_active !== 4'b0001) begin miscompares++; $display("FAIL spawn_active got %b exp 0001", shot_active); end
    vectors++; if (shot_x[9:0] !== 10'd156 || shot_y[9:0] !== 10'd106) begin miscompares++; $display("FAIL spawn_xy got %0d,%0d exp 156,106", shot_x[9:0], shot_y[9:0]); end
    step();
    id_tiro = '0;
    vectors++; if (shot_active !== 4'b0011) begin miscompares++; $display("FAIL spawn2_active got %b exp 0011", shot_active); end
    vectors++; if (shot_x[19:10] !== 10'd396 || shot_y[19:10] !== 10'd138) begin miscompares++; $display("FAIL spawn2_xy got %0d,%0d exp 396,138", shot_x[19:10], shot_y[19:10]); end
  endtask

  task automatic test_full();
    formation_x = 10'd100; formation_y = 10'd50; player_x = 10'd150;
    do_restart();
    for (int b = 0; b < 4; b++) begin
      id_tiro = 24'd1 << b;
      step();
    end
    vectors++; if (shot_active !== 4'b1111) begin miscompares++; $display("FAIL full_active got %b exp 1111", shot_active); end
    vectors++; if (shot_y[39:30] !== 10'd74 || shot_x[39:30] !== 10'd236) begin miscompares++; $display("FAIL full_slot3_nomove got %0d,%0d exp 236,74", shot_x[39:30], shot_y[39:30]); end
    vectors++; if (shot_y[9:0] !== 10'd78) begin miscompares++; $display("FAIL full_slot0_moved got %0d exp 78", shot_y[9:0]); end
    vectors++; if (shot_dropped !== 1'b0) begin miscompares++; $display("FAIL full_nodrop got %b exp 0", shot_dropped); end
    id_tiro = 24'd1 << 4;
    step();
    id_tiro = '0;
    vectors++; if (shot_dropped !== 1'b1 || shot_active !== 4'b1111) begin miscompares++; $display("FAIL full_drop got %b/%b exp 1/1111", shot_dropped, shot_active); end
    step();
    vectors++; if (shot_dropped !== 1'b0) begin miscompares++; $display("FAIL full_drop_pulse got %b exp 0", shot_dropped); end
  endtask

  task automatic test_retire();
    formation_x = 10'd100; formation_y = 10'd452; player_x = 10'd0;
    do_restart();
    id_tiro = 24'd1;
    step();
    id_tiro = '0;
    vectors++; if (shot_active !== 4'b0001 || shot_y[9:0] !== 10'd476) begin miscompares++; $display("FAIL retire_spawn got %b y=%0d exp 0001 y=476", shot_active, shot_y[9:0]); end
    step(); step(); step();
    vectors++; if (shot_active !== 4'b0000) begin miscompares++; $display("FAIL retire_active got %b exp 0000", shot_active); end
    vectors++; if (shot_y[9:0] !== 10'd480) begin miscompares++; $display("FAIL retire_y got %0d exp 480", shot_y[9:0]); end
    vectors++; if (player_hit !== 1'b0 || lives !== 2'd3) begin miscompares++; $display("FAIL retire_nohit got %b/%0d exp 0/3", player_hit, lives); end
  endtask

  task automatic test_hit();
    formation_x = 10'd140; formation_y = 10'd408; player_x = 10'd150;
    do_restart();
    id_tiro = 24'd1;
    step();
    id_tiro = '0;
    vectors++; if (shot_x[9:0] !== 10'd156 || shot_y[9:0] !== 10'd432) begin miscompares++; $display("FAIL hit_spawn got %0d,%0d exp 156,432", shot_x[9:0], shot_y[9:0]); end
    step(); step();
    vectors++; if (player_hit !== 1'b0 || shot_active !== 4'b0001) begin miscompares++; $display("FAIL hit_pretick got %b/%b exp 0/0001", player_hit, shot_active); end
    step();
    vectors++; if (player_hit !== 1'b1 || lives !== 2'd2 || shot_active !== 4'b0000) begin miscompares++; $display("FAIL hit1 got hit=%b lives=%0d act=%b exp 1/2/0000", player_hit, lives, shot_active); end
    id_tiro = 24'd1;
    step();
    id_tiro = '0;
    vectors++; if (player_hit !== 1'b0 || shot_active !== 4'b0001) begin miscompares++; $display("FAIL hit1_pulse got %b/%b exp 0/0001", player_hit, shot_active); end
    step(); step(); step();
    vectors++; if (player_hit !== 1'b1 || lives !== 2'd1 || jogador_vivo !== 1'b1) begin miscompares++; $display("FAIL hit2 got hit=%b lives=%0d vivo=%b exp 1/1/1", player_hit, lives, jogador_vivo); end
    id_tiro = 24'd1;
    step();
    id_tiro = 24'd2;
    step();
    id_tiro = '0;
    vectors++; if (shot_active !== 4'b0011) begin miscompares++; $display("FAIL hit3_pre got %b exp 0011", shot_active); end
    step(); step();
    vectors++; if (player_hit !== 1'b1 || lives !== 2'd0 || jogador_vivo !== 1'b0 || shot_active !== 4'b0000) begin miscompares++; $display("FAIL hit3_dead got hit=%b lives=%0d vivo=%b act=%b exp 1/0/0/0000", player_hit, lives, jogador_vivo, shot_active); end
    id_tiro = 24'd1;
    step();
    id_tiro = '0;
    vectors++; if (shot_active !== 4'b0000 || shot_dropped !== 1'b0) begin miscompares++; $display("FAIL dead_nospawn got %b/%b exp 0000/0", shot_active, shot_dropped); end
    for (int c = 0; c < 8; c++) step();
    vectors++; if (player_hit !== 1'b0 || lives !== 2'd0 || jogador_vivo !== 1'b0) begin miscompares++; $display("FAIL dead_hold got %b/%0d/%b exp 0/0/0", player_hit, lives, jogador_vivo); end
  endtask

  task automatic test_restart_midflight();
    formation_x = 10'd100; formation_y = 10'd50; player_x = 10'd150;
    do_restart();
    vectors++; if (lives !== 2'd3 || jogador_vivo !== 1'b1) begin miscompares++; $display("FAIL restart_revive got %0d/%b exp 3/1", lives, jogador_vivo); end
    for (int b = 0; b < 3; b++) begin
      id_tiro = 24'd1 << b;
      step();
    end
    vectors++; if (shot_active !== 4'b0111) begin miscompares++; $display("FAIL restart_pre got %b exp 0111", shot_active); end
    restart = 1'b1;
    id_tiro = 24'd1 << 3;
    step();
    restart = 1'b0;
    id_tiro = '0;
    vectors++; if (shot_active !== 4'b0000 || shot_x !== 40'd0 || shot_y !== 40'd0) begin miscompares++; $display("FAIL restart_clear got %b %h %h exp 0000 0 0", shot_active, shot_x, shot_y); end
    vectors++; if (lives !== 2'd3 || player_hit !== 1'b0 || shot_dropped !== 1'b0) begin miscompares++; $display("FAIL restart_state got %0d/%b/%b exp 3/0/0", lives, player_hit, shot_dropped); end
    step();
    vectors++; if (shot_active !== 4'b0000) begin miscompares++; $display("FAIL restart_nospawn got %b exp 0000", shot_active); end
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_full();
    test_retire();
    test_hit();
    test_restart_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
